// File: rtl/rename_map_table_if.sv
// Rename-stage bus: dispatch rename request/response, CDB wakeup,
// ROB retire and the free-list dequeue/enqueue handshakes.
//   master : the dispatch/ROB/CDB/free-list side driving requests
//   slave  : rename_map_table
interface rename_map_table_if #(
  parameter int unsigned AR_W = 5,
  parameter int unsigned PR_W = 6
);
  // dispatch rename request
  logic            rename_en;
  logic [AR_W-1:0] dest_ar;
  logic [AR_W-1:0] src1_ar;
  logic [AR_W-1:0] src2_ar;
  // free-list dequeue side
  logic [PR_W-1:0] new_pr;
  logic            new_pr_valid;
  logic            need_pr;
  // rename response
  logic [PR_W-1:0] src1_pr;
  logic            src1_ready;
  logic [PR_W-1:0] src2_pr;
  logic            src2_ready;
  logic [PR_W-1:0] old_pr;
  logic            rename_done;
  logic            rename_stall;
  // completion broadcast
  logic            cdb_en;
  logic [PR_W-1:0] cdb_pr;
  // retire and free-list enqueue side
  logic            retire_en;
  logic [AR_W-1:0] retire_ar;
  logic [PR_W-1:0] retire_pr;
  logic            free_en;
  logic [PR_W-1:0] free_pr;
  // mispredict recovery
  logic            recover_en;

  modport master (
    output rename_en, dest_ar, src1_ar, src2_ar, new_pr, new_pr_valid,
           cdb_en, cdb_pr, retire_en, retire_ar, retire_pr, recover_en,
    input  need_pr, src1_pr, src1_ready, src2_pr, src2_ready, old_pr,
           rename_done, rename_stall, free_en, free_pr
  );

  modport slave (
    input  rename_en, dest_ar, src1_ar, src2_ar, new_pr, new_pr_valid,
           cdb_en, cdb_pr, retire_en, retire_ar, retire_pr, recover_en,
    output need_pr, src1_pr, src1_ready, src2_pr, src2_ready, old_pr,
           rename_done, rename_stall, free_en, free_pr
  );
endinterface

// File: rtl/rename_map_table.sv
// Register rename map table: speculative map, per-PR ready bits and the
// architectural (retirement) map. Renames consume PRs from the free list,
// retires return the superseded PR one cycle later, and a mispredict
// restores the speculative map from the architectural map.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : rename_map_table_if.slave (rename, CDB, retire, recover,
//           free-list dequeue/enqueue)
// Source lookups, old_pr, need_pr, rename_done and rename_stall are
// combinational; free_en/free_pr are registered.
module rename_map_table #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned AR_W      = 5,
  parameter int unsigned PR_W      = 6
) (
  input  logic                clk,
  input  logic                reset,
  rename_map_table_if.slave   bus
);

  logic [PR_W-1:0]      spec_map [ARCH_REGS];
  logic [PR_W-1:0]      arch_map [ARCH_REGS];
  logic [PHYS_REGS-1:0] ready;

  logic rename_done_int;
  logic rename_write;
  logic retire_write;

  // Accept/stall decode and combinational source/old lookups.
  always_comb begin
    rename_done_int = 1'b0;
    rename_write    = 1'b0;
    retire_write    = 1'b0;
    bus.need_pr      = 1'b0;
    bus.rename_done  = 1'b0;
    bus.rename_stall = 1'b0;
    bus.src1_pr      = '0;
    bus.src1_ready   = 1'b1;
    bus.src2_pr      = '0;
    bus.src2_ready   = 1'b1;
    bus.old_pr       = '0;

    rename_done_int = bus.rename_en & ~bus.recover_en &
                      ((bus.dest_ar == '0) | bus.new_pr_valid);
    rename_write    = rename_done_int & (bus.dest_ar != '0);
    retire_write    = bus.retire_en & (bus.retire_ar != '0);

    bus.need_pr      = bus.rename_en & (bus.dest_ar != '0) & ~bus.recover_en;
    bus.rename_done  = rename_done_int;
    bus.rename_stall = bus.rename_en & ~rename_done_int;

    // AR 0 is the zero register: PR 0, always ready.
    if (bus.src1_ar != '0) begin
      bus.src1_pr    = spec_map[bus.src1_ar];
      bus.src1_ready = ready[bus.src1_pr] |
                       (bus.cdb_en & (bus.cdb_pr == bus.src1_pr));
    end
    if (bus.src2_ar != '0) begin
      bus.src2_pr    = spec_map[bus.src2_ar];
      bus.src2_ready = ready[bus.src2_pr] |
                       (bus.cdb_en & (bus.cdb_pr == bus.src2_pr));
    end
    if (bus.dest_ar != '0) begin
      bus.old_pr = spec_map[bus.dest_ar];
    end
  end

  // Architectural map and the registered free-list enqueue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        arch_map[i] <= PR_W'(i);
      end
      bus.free_en <= 1'b0;
      bus.free_pr <= '0;
    end else begin
      bus.free_en <= retire_write;
      if (retire_write) begin
        arch_map[bus.retire_ar] <= bus.retire_pr;
        bus.free_pr             <= arch_map[bus.retire_ar];
      end
    end
  end

  // Speculative map and ready bits; recover overrides rename.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        spec_map[i] <= PR_W'(i);
      end
      ready <= '1;
    end else if (bus.recover_en) begin
      // Restore from the arch map with this cycle's retire folded in.
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        if (retire_write && (bus.retire_ar == AR_W'(i))) begin
          spec_map[i] <= bus.retire_pr;
        end else begin
          spec_map[i] <= arch_map[i];
        end
      end
      ready <= '1;
    end else begin
      if (bus.cdb_en) begin
        ready[bus.cdb_pr] <= 1'b1;
      end
      // Issued after the CDB set so a same-PR clear wins.
      if (rename_write) begin
        spec_map[bus.dest_ar] <= bus.new_pr;
        ready[bus.new_pr]     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: one-cycle vector table followed by
// a hand-written mid-operation reset sequence.
module tb_rename_map_table;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rename_map_table_if #(.AR_W(5), .PR_W(6)) bus ();

  rename_map_table dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    // inputs
    logic       ren;
    logic [4:0] dest;
    logic [4:0] s1;
    logic [4:0] s2;
    logic [5:0] npr;
    logic       nv;
    logic       cdb;
    logic [5:0] cpr;
    logic       ret;
    logic [4:0] rar;
    logic [5:0] rpr;
    logic       rec;
    // expected outputs, sampled in the same cycle
    logic [5:0] e_s1pr;
    logic       e_s1r;
    logic [5:0] e_s2pr;
    logic       e_s2r;
    logic [5:0] e_old;
    logic       e_need;
    logic       e_done;
    logic       e_stall;
    logic       e_fen;
    logic [5:0] e_fpr;
    logic       chk_fpr;
  } vec_t;

  localparam int unsigned NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.rename_en    = v.ren;
    bus.dest_ar      = v.dest;
    bus.src1_ar      = v.s1;
    bus.src2_ar      = v.s2;
    bus.new_pr       = v.npr;
    bus.new_pr_valid = v.nv;
    bus.cdb_en       = v.cdb;
    bus.cdb_pr       = v.cpr;
    bus.retire_en    = v.ret;
    bus.retire_ar    = v.rar;
    bus.retire_pr    = v.rpr;
    bus.recover_en   = v.rec;
  endtask

  task automatic idle();
    bus.rename_en    = 1'b0;
    bus.dest_ar      = '0;
    bus.src1_ar      = '0;
    bus.src2_ar      = '0;
    bus.new_pr       = '0;
    bus.new_pr_valid = 1'b0;
    bus.cdb_en       = 1'b0;
    bus.cdb_pr       = '0;
    bus.retire_en    = 1'b0;
    bus.retire_ar    = '0;
    bus.retire_pr    = '0;
    bus.recover_en   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle();

    // Field order: ren,dest,s1,s2,npr,nv, cdb,cpr, ret,rar,rpr, rec,
    //   e_s1pr,e_s1r,e_s2pr,e_s2r,e_old, e_need,e_done,e_stall, e_fen,e_fpr,chk_fpr
    vecs[0]  = '{0,0,5,0,0,0,   0,0,  0,0,0,  0,  5,1, 0,1, 0,  0,0,0, 0,0,1};
    vecs[1]  = '{1,3,3,4,32,1,  0,0,  0,0,0,  0,  3,1, 4,1, 3,  1,1,0, 0,0,0};
    vecs[2]  = '{0,0,3,0,0,0,   0,0,  0,0,0,  0, 32,0, 0,1, 0,  0,0,0, 0,0,0};
    vecs[3]  = '{0,0,3,0,0,0,   1,32, 0,0,0,  0, 32,1, 0,1, 0,  0,0,0, 0,0,0};
    vecs[4]  = '{0,0,3,0,0,0,   0,0,  0,0,0,  0, 32,1, 0,1, 0,  0,0,0, 0,0,0};
    vecs[5]  = '{1,4,4,3,33,0,  0,0,  0,0,0,  0,  4,1,32,1, 4,  1,0,1, 0,0,0};
    vecs[6]  = '{0,0,4,0,0,0,   0,0,  1,3,32, 0,  4,1, 0,1, 0,  0,0,0, 0,0,0};
    vecs[7]  = '{0,0,3,0,0,0,   0,0,  1,0,5,  0, 32,1, 0,1, 0,  0,0,0, 1,3,1};
    vecs[8]  = '{0,0,3,0,0,0,   0,0,  0,0,0,  0, 32,1, 0,1, 0,  0,0,0, 0,0,0};
    vecs[9]  = '{1,7,7,0,33,1,  0,0,  0,0,0,  0,  7,1, 0,1, 7,  1,1,0, 0,0,0};
    vecs[10] = '{1,7,7,3,34,1,  0,0,  0,0,0,  1, 33,0,32,1,33,  0,0,1, 0,0,0};
    vecs[11] = '{0,0,7,3,0,0,   0,0,  0,0,0,  0,  7,1,32,1, 0,  0,0,0, 0,0,0};
    vecs[12] = '{1,5,5,5,40,1,  1,40, 0,0,0,  0,  5,1, 5,1, 5,  1,1,0, 0,0,0};
    vecs[13] = '{0,0,5,0,0,0,   0,0,  1,5,40, 1, 40,0, 0,1, 0,  0,0,0, 0,0,0};
    vecs[14] = '{0,0,5,7,0,0,   0,0,  0,0,0,  0, 40,1, 7,1, 0,  0,0,0, 1,5,1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i]);
      #1;
      check("src1_pr",      i, 8'(bus.src1_pr),      8'(vecs[i].e_s1pr));
      check("src1_ready",   i, 8'(bus.src1_ready),   8'(vecs[i].e_s1r));
      check("src2_pr",      i, 8'(bus.src2_pr),      8'(vecs[i].e_s2pr));
      check("src2_ready",   i, 8'(bus.src2_ready),   8'(vecs[i].e_s2r));
      check("old_pr",       i, 8'(bus.old_pr),       8'(vecs[i].e_old));
      check("need_pr",      i, 8'(bus.need_pr),      8'(vecs[i].e_need));
      check("rename_done",  i, 8'(bus.rename_done),  8'(vecs[i].e_done));
      check("rename_stall", i, 8'(bus.rename_stall), 8'(vecs[i].e_stall));
      check("free_en",      i, 8'(bus.free_en),      8'(vecs[i].e_fen));
      if (vecs[i].chk_fpr) begin
        check("free_pr", i, 8'(bus.free_pr), 8'(vecs[i].e_fpr));
      end
      @(negedge clk);
    end

    // Mid-operation reset: rename AR9->41 and retire AR6->50 in one cycle.
    idle();
    bus.rename_en    = 1'b1;
    bus.dest_ar      = 5'd9;
    bus.new_pr       = 6'd41;
    bus.new_pr_valid = 1'b1;
    bus.retire_en    = 1'b1;
    bus.retire_ar    = 5'd6;
    bus.retire_pr    = 6'd50;
    #1;
    check("rst_seq_done", 100, 8'(bus.rename_done), 8'd1);
    @(negedge clk);
    idle();
    bus.src1_ar = 5'd9;
    #1;
    check("rst_seq_pre_map",   101, 8'(bus.src1_pr),   8'd41);
    check("rst_seq_pre_rdy",   101, 8'(bus.src1_ready), 8'd0);
    check("rst_seq_pre_fen",   101, 8'(bus.free_en),   8'd1);
    check("rst_seq_pre_fpr",   101, 8'(bus.free_pr),   8'd6);
    #2;
    reset = 1'b0;
    #1;
    check("rst_seq_map",   102, 8'(bus.src1_pr),    8'd9);
    check("rst_seq_rdy",   102, 8'(bus.src1_ready), 8'd1);
    check("rst_seq_fen",   102, 8'(bus.free_en),    8'd0);
    check("rst_seq_fpr",   102, 8'(bus.free_pr),    8'd0);
    @(negedge clk);
    reset = 1'b1;
    // Recover exposes the arch map: AR6 must be back to identity.
    bus.recover_en = 1'b1;
    @(negedge clk);
    idle();
    bus.src1_ar = 5'd6;
    bus.src2_ar = 5'd9;
    #1;
    check("rst_seq_arch6", 103, 8'(bus.src1_pr),    8'd6);
    check("rst_seq_arch9", 103, 8'(bus.src2_pr),    8'd9);
    check("rst_seq_rdy9",  103, 8'(bus.src2_ready), 8'd1);
    check("rst_seq_fen2",  103, 8'(bus.free_en),    8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Register-rename stage directly upstream of the free list in the out-of-order core.
- Holds the speculative map (architectural register -> physical register), per-physical-register ready bits, and the architectural (retirement) map.
- At dispatch it consumes the PR dequeued from the free list. At retire it returns the superseded PR to the free list's enqueue side.
- On a branch mispredict it recovers the speculative map from the architectural map.

Parameters:
- ARCH_REGS, 32, number of architectural registers; AR 0 is hardwired zero and never renamed.
- PHYS_REGS, 64, number of physical registers.
- AR_W, 5, architectural index width.
- PR_W, 6, physical index width; equals PHYS_REG_IDX_SZ+1, matching free-list dequeue_pr/enqueue_pr.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- rename_en  in  1  dispatch requests a rename this cycle.
- dest_ar  in  AR_W  destination AR; 0 = no destination.
- src1_ar  in  AR_W  source 1 AR.
- src2_ar  in  AR_W  source 2 AR.
- new_pr  in  PR_W  PR from free list (dequeue_pr).
- new_pr_valid  in  1  free list granted a PR (was_dequeued).
- need_pr  out  1  drives free-list dequeue_en; = rename_en & (dest_ar!=0) & ~recover_en.
- src1_pr  out  PR_W  current mapping of src1_ar.
- src1_ready  out  1  src1 value available.
- src2_pr  out  PR_W  current mapping of src2_ar.
- src2_ready  out  1  src2 value available.
- old_pr  out  PR_W  previous mapping of dest_ar (Told, sent to ROB).
- rename_done  out  1  rename accepted this cycle.
- rename_stall  out  1  rename requested but not accepted.
- cdb_en  in  1  CDB broadcast valid.
- cdb_pr  in  PR_W  PR completed on CDB.
- retire_en  in  1  ROB head retires with a destination.
- retire_ar  in  AR_W  retiring destination AR.
- retire_pr  in  PR_W  retiring PR (becomes architectural).
- free_en  out  1  drives free-list enqueue_en.
- free_pr  out  PR_W  drives free-list enqueue_pr.
- recover_en  in  1  mispredict, restore speculative map.

Behaviour:

Reset (reset=0, async):
- spec_map[i] = arch_map[i] = i for all i.
- ready[p] = 1 for all p.
- free_en = 0, free_pr = 0.
- The free list's initial contents are PRs ARCH_REGS..PHYS_REGS-1.
- Reset asserted mid-operation discards all in-flight updates immediately.

Source lookup:
- Combinational, same cycle: srcN_pr = spec_map[srcN_ar] using the pre-edge state.
- srcN_ready = ready[srcN_pr] | (cdb_en & cdb_pr==srcN_pr). This is a CDB bypass.
- srcN_ar==0 always gives PR 0, ready=1.
- old_pr = spec_map[dest_ar], combinational. A source equal to dest_ar returns the old mapping, not new_pr.

Rename accept:
- rename_done = rename_en & ~recover_en & (dest_ar==0 | new_pr_valid).
- rename_stall = rename_en & ~rename_done.
- On rename_done with dest_ar!=0, at posedge: spec_map[dest_ar] <= new_pr and ready[new_pr] <= 0.
- dest_ar==0: no PR consumed, no state change; old_pr = 0.
- A stalled rename changes no state.

CDB:
- At posedge: ready[cdb_pr] <= 1.
- If the same cycle's rename clears the same PR, the rename clear wins (protocol error, defined anyway).

Retire:
- At posedge: arch_map[retire_ar] <= retire_pr.
- At the same edge: free_en <= 1 and free_pr <= pre-edge arch_map[retire_ar]. This is exactly 1 cycle of latency to the free list.
- retire_ar==0 is ignored: free_en <= 0.
- With no retire, free_en <= 0 the following cycle.

Recover:
- At posedge: spec_map <= arch_map with the same-cycle retire update already applied, and all ready bits <= 1.
- Rename is blocked that cycle (need_pr=0, rename_done=0). CDB writes that cycle are irrelevant.
- Retire's free_en/free_pr still issue normally.
- Recover takes one cycle; rename may proceed the next cycle.

Priority per cycle: recover > rename for the spec map; ready clear > ready set; retire always applied.

Test Plan:
- Reset release, no activity -> src1_ar=5 gives src1_pr=5, src1_ready=1; free_en=0; need_pr=0.
- rename_en=1, dest_ar=3, src1_ar=3, new_pr=32, new_pr_valid=1 -> same cycle: src1_pr=3, old_pr=3, rename_done=1. Next cycle src1_ar=3 gives pr 32, ready=0.
- After previous step, cdb_en=1, cdb_pr=32, src1_ar=3 -> same cycle src1_ready=1 via bypass. Next cycle ready stays 1 with cdb_en=0.
- rename_en=1, dest_ar=4, new_pr_valid=0 -> need_pr=1, rename_stall=1, rename_done=0. spec_map[4] stays 4.
- retire_en=1, retire_ar=3, retire_pr=32 -> next cycle free_en=1, free_pr=3. Following cycle free_en=0. retire_ar=0 yields no free.
- Rename AR7 -> 33, then recover_en=1 together with rename_en=1 -> rename_done=0. Next cycle src1_ar=7 gives 7, ready=1. Assert reset=0 mid-sequence -> map is identity and free_en=0 immediately.
